// File: rtl/audio_tone_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_tone_gen_pkg
//  Description : Shared types and constants for the square-wave tone
//                generator: FSM states, PWM period and the note table.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_tone_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int  PWM_PERIOD = 31;
    localparam real BASE_HZ    = 261.63;

    // 2^(k/12) for the 15 semitones starting at the base note.
    function automatic real semitone_ratio(input int k);
        case (k)
            0:       return 1.0;
            1:       return 1.0594630944;
            2:       return 1.1224620483;
            3:       return 1.1892071150;
            4:       return 1.2599210499;
            5:       return 1.3348398542;
            6:       return 1.4142135624;
            7:       return 1.4983070769;
            8:       return 1.5874010520;
            9:       return 1.6817928305;
            10:      return 1.7817974363;
            11:      return 1.8877486254;
            12:      return 2.0;
            13:      return 2.1189261887;
            14:      return 2.2449240966;
            default: return 1.0;
        endcase
    endfunction

    // Half-period in clocks for note n (1..15); index 0 is a harmless filler.
    function automatic int half_period(input int clk_hz, input int n);
        real h;
        int  r;
        if (n < 1 || n > 15) return 1;
        h = $itor(clk_hz) / (2.0 * BASE_HZ * semitone_ratio(n - 1));
        r = $rtoi(h + 0.5);
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_tone_gen_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pwm
//  Description : Free-running 0..30 PWM counter and registered comparator
//                that gates the tone phase with the current volume.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_pwm
    import audio_tone_gen_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       phase,
    input  logic [4:0] level,
    output logic       pwm_out
);

    logic [4:0] pwm_cnt;

    // Counter never stops so the duty pattern is independent of note starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= 5'd0;
            pwm_out <= 1'b0;
        end else begin
            if (pwm_cnt == 5'(PWM_PERIOD - 1)) pwm_cnt <= 5'd0;
            else                               pwm_cnt <= pwm_cnt + 5'd1;
            pwm_out <= active & phase & (pwm_cnt < level);
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module      : audio_tone_gen
//  Description : Square-wave tone generator with volume-controlled PWM and
//                linear release decay. Driven directly by the processor
//                audio port; pwm_out feeds the board audio pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_tone_gen
    import audio_tone_gen_pkg::*;
#(
    parameter int CLK_HZ    = 25000000,
    parameter int DECAY_DIV = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       audioEn,
    input  logic [3:0] audioSel,
    input  logic [4:0] audioVol,
    output logic       pwm_out,
    output logic       busy,
    output logic [4:0] cur_vol
);

    // Note 1 has the longest half-period, so it sizes the tone counter.
    localparam int TONE_W  = $clog2(half_period(CLK_HZ, 1) + 1);
    localparam int DECAY_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_DIV - 1);

    logic [TONE_W-1:0] half_m1 [16];

    for (genvar g = 0; g < 16; g++) begin : g_half_tbl
        localparam int H = half_period(CLK_HZ, g);
        assign half_m1[g] = TONE_W'(H - 1);
    end

    state_t             state,     state_nxt;
    logic [3:0]         note,      note_nxt;
    logic [4:0]         vol_nxt;
    logic               phase,     phase_nxt;
    logic [TONE_W-1:0]  tone_cnt,  tone_nxt;
    logic [DECAY_W-1:0] decay_cnt, decay_nxt;
    logic               start, do_load, do_idle, do_tone;

    assign start = audioEn && (audioSel != 4'd0);
    assign busy  = (state != ST_IDLE);

    // State and datapath registers; reset abandons any note in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            note      <= 4'd0;
            cur_vol   <= 5'd0;
            phase     <= 1'b0;
            tone_cnt  <= '0;
            decay_cnt <= '0;
        end else begin
            state     <= state_nxt;
            note      <= note_nxt;
            cur_vol   <= vol_nxt;
            phase     <= phase_nxt;
            tone_cnt  <= tone_nxt;
            decay_cnt <= decay_nxt;
        end
    end

    // Next-state logic: a note (re)start overrides decay, idle clears everything.
    always_comb begin
        state_nxt = state;
        note_nxt  = note;
        vol_nxt   = cur_vol;
        phase_nxt = phase;
        tone_nxt  = tone_cnt;
        decay_nxt = decay_cnt;
        do_load   = 1'b0;
        do_idle   = 1'b0;
        do_tone   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) do_load = 1'b1;
                else       do_idle = 1'b1;
            end
            ST_PLAY: begin
                if (!start) begin
                    state_nxt = ST_RELEASE;
                    decay_nxt = '0;
                    do_tone   = 1'b1;
                end else if (audioSel != note) begin
                    do_load = 1'b1;
                end else begin
                    vol_nxt = audioVol;
                    do_tone = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (start) begin
                    do_load = 1'b1;
                end else if (cur_vol == 5'd0) begin
                    do_idle = 1'b1;
                end else if (decay_cnt == DECAY_LAST) begin
                    decay_nxt = '0;
                    vol_nxt   = cur_vol - 5'd1;
                    if (cur_vol == 5'd1) do_idle = 1'b1;
                    else                 do_tone = 1'b1;
                end else begin
                    decay_nxt = decay_cnt + 1'b1;
                    do_tone   = 1'b1;
                end
            end
            default: do_idle = 1'b1;
        endcase

        if (do_tone) begin
            if (tone_cnt == '0) begin
                phase_nxt = ~phase;
                tone_nxt  = half_m1[note];
            end else begin
                tone_nxt  = tone_cnt - 1'b1;
            end
        end

        if (do_load) begin
            state_nxt = ST_PLAY;
            note_nxt  = audioSel;
            vol_nxt   = audioVol;
            phase_nxt = 1'b0;
            tone_nxt  = half_m1[audioSel];
            decay_nxt = '0;
        end

        if (do_idle) begin
            state_nxt = ST_IDLE;
            note_nxt  = 4'd0;
            vol_nxt   = 5'd0;
            phase_nxt = 1'b0;
            tone_nxt  = '0;
            decay_nxt = '0;
        end
    end

    audio_pwm u_pwm (
        .clk     (clk),
        .reset   (reset),
        .active  (busy),
        .phase   (phase),
        .level   (cur_vol),
        .pwm_out (pwm_out)
    );

endmodule
`default_nettype wire
